gshare_train_tracker: RTL and testbench

//  Closes the gshare predictor loop from the consumer side. Captures each issued prediction
//  (pc, history, predicted direction) in an in-order in-flight queue. Pairs each queued entry

---
 rtl/gshare_pkg.sv | 32 +++
 rtl/gshare_inflight_fifo.sv | 66 ++++++
 rtl/gshare_train_tracker.sv | 114 +++++++++++
 tb/tb_gshare_train_tracker.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/gshare_pkg.sv
// Shared types for the gshare predictor and its training loop.
package gshare_pkg;

    localparam int GSHARE_N = 7;

    typedef struct packed {
        logic [GSHARE_N-1:0] pc;
        logic [GSHARE_N-1:0] history;
        logic                pred_taken;
    } inflight_entry_t;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        LNT = 2'b01,
        LT  = 2'b10,
        ST  = 2'b11
    } ctr_state_t;

    // Saturating 2-bit counter step used by the predictor tables.
    function automatic ctr_state_t ctr_next(input ctr_state_t s, input logic taken);
        ctr_state_t n;
        case (s)
            SNT:     n = taken ? LNT : SNT;
            LNT:     n = taken ? LT  : SNT;
            LT:      n = taken ? ST  : LNT;
            ST:      n = taken ? ST  : LT;
            default: n = SNT;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/gshare_inflight_fifo.sv
// Circular in-order buffer of issued predictions; flush empties it in one cycle.
module gshare_inflight_fifo
    import gshare_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    areset_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  inflight_entry_t         wdata,
    output inflight_entry_t         rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]   head_r;
    logic [AW-1:0]   tail_r;
    logic [AW:0]     count_r;
    inflight_entry_t mem_r [DEPTH];
    logic            push_s;
    logic            pop_s;

    assign full   = (count_r == (AW+1)'(DEPTH));
    assign empty  = (count_r == (AW+1)'(0));
    assign count  = count_r;
    assign rdata  = mem_r[head_r];
    assign push_s = push & ~full & ~flush;
    assign pop_s  = pop & ~empty;

    // Pointer and occupancy tracking; flush drops everything behind the head.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            head_r  <= AW'(0);
            tail_r  <= AW'(0);
            count_r <= (AW+1)'(0);
        end else if (flush) begin
            head_r  <= tail_r;
            count_r <= (AW+1)'(0);
        end else begin
            if (push_s) begin
                tail_r <= tail_r + AW'(1);
            end
            if (pop_s) begin
                head_r <= head_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage, deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[tail_r] <= wdata;
        end
    end

endmodule

// File: rtl/gshare_train_tracker.sv
// Pairs each in-flight gshare prediction with its resolved outcome and emits a
// one-cycle training pulse; wrong-path predictions are squashed after a mispredict.
module gshare_train_tracker
    import gshare_pkg::*;
#(
    parameter int N     = GSHARE_N,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    areset_n,
    input  logic                    pred_valid,
    input  logic [N-1:0]            pred_pc,
    input  logic                    pred_taken,
    input  logic [N-1:0]            pred_history,
    output logic                    pred_ready,
    input  logic                    resolve_valid,
    input  logic                    resolve_taken,
    output logic                    train_valid,
    output logic                    train_taken,
    output logic                    train_mispredicted,
    output logic [N-1:0]            train_history,
    output logic [N-1:0]            train_pc,
    output logic [$clog2(DEPTH):0]  inflight_count,
    output logic                    overflow_err,
    output logic                    underflow_err
);

    inflight_entry_t         wr_entry_s;
    inflight_entry_t         head_s;
    logic                    full_s;
    logic                    empty_s;
    logic [$clog2(DEPTH):0]  count_s;
    logic                    pop_s;
    logic                    push_s;
    logic                    mispredict_s;
    logic                    squash_s;

    logic                    train_valid_r;
    logic                    train_taken_r;
    logic                    train_mispredicted_r;
    logic [N-1:0]            train_history_r;
    logic [N-1:0]            train_pc_r;
    logic                    overflow_err_r;
    logic                    underflow_err_r;

    assign wr_entry_s = '{pc: pred_pc, history: pred_history, pred_taken: pred_taken};

    // Squash spans the mispredicting cycle and the following one, until the
    // predictor's history reload becomes visible.
    always_comb begin
        pop_s        = resolve_valid & ~empty_s;
        mispredict_s = pop_s & (resolve_taken ^ head_s.pred_taken);
        squash_s     = mispredict_s | (train_valid_r & train_mispredicted_r);
        push_s       = pred_valid & ~full_s & ~squash_s;
    end

    gshare_inflight_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .areset_n (areset_n),
        .push     (push_s),
        .pop      (pop_s),
        .flush    (mispredict_s),
        .wdata    (wr_entry_s),
        .rdata    (head_s),
        .full     (full_s),
        .empty    (empty_s),
        .count    (count_s)
    );

    // Registered training pulse and sticky error flags.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            train_valid_r        <= 1'b0;
            train_taken_r        <= 1'b0;
            train_mispredicted_r <= 1'b0;
            train_history_r      <= N'(0);
            train_pc_r           <= N'(0);
            overflow_err_r       <= 1'b0;
            underflow_err_r      <= 1'b0;
        end else begin
            train_valid_r <= pop_s;
            if (pop_s) begin
                train_taken_r        <= resolve_taken;
                train_mispredicted_r <= mispredict_s;
                train_history_r      <= head_s.history;
                train_pc_r           <= head_s.pc;
            end else begin
                train_taken_r        <= 1'b0;
                train_mispredicted_r <= 1'b0;
                train_history_r      <= N'(0);
                train_pc_r           <= N'(0);
            end
            if (pred_valid & full_s & ~squash_s) begin
                overflow_err_r <= 1'b1;
            end
            if (resolve_valid & empty_s) begin
                underflow_err_r <= 1'b1;
            end
        end
    end

    assign pred_ready         = ~full_s;
    assign inflight_count     = count_s;
    assign train_valid        = train_valid_r;
    assign train_taken        = train_taken_r;
    assign train_mispredicted = train_mispredicted_r;
    assign train_history      = train_history_r;
    assign train_pc           = train_pc_r;
    assign overflow_err       = overflow_err_r;
    assign underflow_err      = underflow_err_r;

endmodule

// File: tb/tb_gshare_train_tracker.sv
// Directed scenarios plus randomized traffic against a queue-based reference model.
module tb_gshare_train_tracker;

    localparam int N     = 7;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         areset_n = 1'b0;
    logic         pred_valid = 1'b0;
    logic [N-1:0] pred_pc = '0;
    logic         pred_taken = 1'b0;
    logic [N-1:0] pred_history = '0;
    logic         pred_ready;
    logic         resolve_valid = 1'b0;
    logic         resolve_taken = 1'b0;
    logic         train_valid;
    logic         train_taken;
    logic         train_mispredicted;
    logic [N-1:0] train_history;
    logic [N-1:0] train_pc;
    logic [3:0]   inflight_count;
    logic         overflow_err;
    logic         underflow_err;

    gshare_train_tracker #(.N(N), .DEPTH(DEPTH)) dut (
        .clk                (clk),
        .areset_n           (areset_n),
        .pred_valid         (pred_valid),
        .pred_pc            (pred_pc),
        .pred_taken         (pred_taken),
        .pred_history       (pred_history),
        .pred_ready         (pred_ready),
        .resolve_valid      (resolve_valid),
        .resolve_taken      (resolve_taken),
        .train_valid        (train_valid),
        .train_taken        (train_taken),
        .train_mispredicted (train_mispredicted),
        .train_history      (train_history),
        .train_pc           (train_pc),
        .inflight_count     (inflight_count),
        .overflow_err       (overflow_err),
        .underflow_err      (underflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] pc;
        logic [N-1:0] hist;
        logic         taken;
    } ent_t;

    ent_t         q[$];
    logic         m_tv, m_tt, m_tmis, m_ovf, m_unf;
    logic [N-1:0] m_pc, m_hist;
    int           n_cmp = 0;
    int           n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_tv = 1'b0; m_tt = 1'b0; m_tmis = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        m_pc = '0; m_hist = '0;
    endtask

    // One clock of behaviour: resolve oldest, flush on mispredict, then accept unless squashed.
    task automatic model_step(input logic pv, input logic [N-1:0] pc, input logic pt,
                              input logic [N-1:0] ph, input logic rv, input logic rt);
        logic sq, rdy;
        ent_t e;
        sq  = (rv && q.size() > 0 && rt != q[0].taken) || (m_tv && m_tmis);
        rdy = (q.size() < DEPTH);
        if (rv && q.size() > 0) begin
            e = q.pop_front();
            m_tv = 1'b1; m_tt = rt; m_tmis = (rt != e.taken); m_pc = e.pc; m_hist = e.hist;
            if (m_tmis) q.delete();
        end else begin
            m_tv = 1'b0; m_tt = 1'b0; m_tmis = 1'b0; m_pc = '0; m_hist = '0;
            if (rv) m_unf = 1'b1;
        end
        if (pv && !sq) begin
            if (rdy) q.push_back('{pc: pc, hist: ph, taken: pt});
            else     m_ovf = 1'b1;
        end
    endtask

    task automatic compare_all();
        check_eq("train_valid", 32'(train_valid), 32'(m_tv));
        check_eq("train_taken", 32'(train_taken), 32'(m_tt));
        check_eq("train_mispredicted", 32'(train_mispredicted), 32'(m_tmis));
        check_eq("train_pc", 32'(train_pc), 32'(m_pc));
        check_eq("train_history", 32'(train_history), 32'(m_hist));
        check_eq("inflight_count", 32'(inflight_count), 32'(q.size()));
        check_eq("pred_ready", 32'(pred_ready), 32'(q.size() != DEPTH));
        check_eq("overflow_err", 32'(overflow_err), 32'(m_ovf));
        check_eq("underflow_err", 32'(underflow_err), 32'(m_unf));
    endtask

    task automatic step(input logic pv, input logic [N-1:0] pc, input logic pt,
                        input logic [N-1:0] ph, input logic rv, input logic rt);
        @(negedge clk);
        pred_valid = pv; pred_pc = pc; pred_taken = pt; pred_history = ph;
        resolve_valid = rv; resolve_taken = rt;
        @(posedge clk);
        #1;
        model_step(pv, pc, pt, ph, rv, rt);
        compare_all();
    endtask

    task automatic push(input logic [N-1:0] pc, input logic pt, input logic [N-1:0] ph);
        step(1'b1, pc, pt, ph, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        pred_valid = 1'b0; resolve_valid = 1'b0;
        areset_n = 1'b0;
        #1;
        check_eq("rst_count", 32'(inflight_count), 32'd0);
        check_eq("rst_train_valid", 32'(train_valid), 32'd0);
        check_eq("rst_train_pc", 32'(train_pc), 32'd0);
        check_eq("rst_overflow", 32'(overflow_err), 32'd0);
        check_eq("rst_underflow", 32'(underflow_err), 32'd0);
        check_eq("rst_pred_ready", 32'(pred_ready), 32'd1);
        @(negedge clk);
        areset_n = 1'b1;
        model_clear();
    endtask

    initial begin
        logic pv, rv, rt, pt;
        logic [N-1:0] pc, ph;
        int bias;
        model_clear();
        repeat (2) @(negedge clk);
        areset_n = 1'b1;

        // Reset discards queued entries
        push(7'h11, 1'b1, 7'h01);
        push(7'h22, 1'b0, 7'h02);
        push(7'h33, 1'b1, 7'h03);
        check_eq("pre_reset_count", 32'(inflight_count), 32'd3);
        do_reset();

        // Correct prediction
        push(7'h12, 1'b1, 7'h05);
        check_eq("t2_count_before", 32'(inflight_count), 32'd1);
        step(1'b0, 7'h00, 1'b0, 7'h00, 1'b1, 1'b1);
        check_eq("t2_valid", 32'(train_valid), 32'd1);
        check_eq("t2_pc", 32'(train_pc), 32'h12);
        check_eq("t2_hist", 32'(train_history), 32'h05);
        check_eq("t2_mispred", 32'(train_mispredicted), 32'd0);
        check_eq("t2_count_after", 32'(inflight_count), 32'd0);
        idle();
        check_eq("t2_pulse_one_cycle", 32'(train_valid), 32'd0);

        // Mispredict flushes younger entries and squashes two cycles of predictions
        push(7'h01, 1'b0, 7'h0a);
        push(7'h02, 1'b0, 7'h0b);
        push(7'h03, 1'b0, 7'h0c);
        step(1'b1, 7'h04, 1'b1, 7'h0d, 1'b1, 1'b1);
        check_eq("t3_pc", 32'(train_pc), 32'h01);
        check_eq("t3_mispred", 32'(train_mispredicted), 32'd1);
        check_eq("t3_count_T", 32'(inflight_count), 32'd0);
        step(1'b1, 7'h05, 1'b1, 7'h0e, 1'b0, 1'b0);
        check_eq("t3_count_T1", 32'(inflight_count), 32'd0);
        step(1'b1, 7'h06, 1'b0, 7'h0f, 1'b0, 1'b0);
        check_eq("t3_count_T2", 32'(inflight_count), 32'd1);
        check_eq("t3_no_overflow", 32'(overflow_err), 32'd0);
        step(1'b0, 7'h00, 1'b0, 7'h00, 1'b1, 1'b0);
        check_eq("t3_survivor_pc", 32'(train_pc), 32'h06);

        // Push and correct pop in the same cycle
        push(7'h31, 1'b1, 7'h01);
        push(7'h32, 1'b1, 7'h02);
        push(7'h33, 1'b1, 7'h03);
        step(1'b1, 7'h34, 1'b1, 7'h04, 1'b1, 1'b1);
        check_eq("t6_count", 32'(inflight_count), 32'd3);
        check_eq("t6_head_pc", 32'(train_pc), 32'h31);
        for (int i = 0; i < 3; i++) step(1'b0, 7'h00, 1'b0, 7'h00, 1'b1, 1'b1);
        check_eq("t6_tail_pc", 32'(train_pc), 32'h34);

        // Full, overflow and wrap-around ordering
        for (int i = 0; i < DEPTH; i++) push(7'(8'h40 + i), 1'b1, 7'(i));
        check_eq("t4_ready_full", 32'(pred_ready), 32'd0);
        push(7'h7f, 1'b1, 7'h7f);
        check_eq("t4_overflow", 32'(overflow_err), 32'd1);
        check_eq("t4_count_full", 32'(inflight_count), 32'd8);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 7'h00, 1'b0, 7'h00, 1'b1, 1'b1);
            check_eq("t4_order_a", 32'(train_pc), 32'h40 + 32'(i));
        end
        for (int i = 0; i < DEPTH; i++) push(7'(8'h50 + i), 1'b0, 7'(i));
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 7'h00, 1'b0, 7'h00, 1'b1, 1'b0);
            check_eq("t4_order_b", 32'(train_pc), 32'h50 + 32'(i));
        end

        // Underflow is sticky
        step(1'b0, 7'h00, 1'b0, 7'h00, 1'b1, 1'b1);
        check_eq("t5_no_pulse", 32'(train_valid), 32'd0);
        check_eq("t5_underflow", 32'(underflow_err), 32'd1);
        repeat (10) idle();
        check_eq("t5_sticky", 32'(underflow_err), 32'd1);
        check_eq("t4_overflow_sticky", 32'(overflow_err), 32'd1);
        do_reset();

        // Randomized traffic with alternating fill/drain bias and occasional resets
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 700 == 699) do_reset();
            bias = ((cyc / 50) % 2 == 0) ? 75 : 30;
            pv = ($urandom_range(0, 99) < bias);
            rv = ($urandom_range(0, 99) < (100 - bias));
            pt = 1'($urandom_range(0, 1));
            pc = 7'($urandom);
            ph = 7'($urandom);
            if (q.size() > 0) rt = q[0].taken ^ ($urandom_range(0, 99) < 15);
            else              rt = 1'($urandom_range(0, 1));
            step(pv, pc, pt, ph, rv, rt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
